// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches words over an imem req/ack
// handshake, presents them to the decoder and retries fetches that time out.
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_pc_src,
    input  logic [ADDR_WIDTH-1:0] i_branch_target,
    input  logic                  i_stall,
    output logic                  o_imem_req,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_ack,
    input  logic [31:0]           i_imem_rdata,
    output logic [31:0]           o_instr,
    output logic [ADDR_WIDTH-1:0] o_instr_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus8,
    output logic                  o_instr_valid,
    output logic [7:0]            o_retry_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_RETRY = 2'd2
    } state_t;

    localparam int            WW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic [31:0]           r_instr;
    logic                  r_valid;
    logic [7:0]            r_retry_cnt;
    logic [WW-1:0]         r_wait_cnt;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_target = i_branch_target & ~ADDR_WIDTH'(3);

    // Request is gated by reset so it is low in the reset cycle and rises in
    // the very first cycle after release, with no extra idle cycle.
    assign o_imem_req    = (r_state == S_FETCH) && !i_reset;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_pc_plus8    = r_instr_pc + ADDR_WIDTH'(8);
    assign o_instr_valid = r_valid;
    assign o_retry_cnt   = r_retry_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_valid     <= 1'b0;
            r_retry_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // Ack takes priority over a simultaneous timeout expiry.
                    if (i_imem_ack) begin
                        r_instr    <= i_imem_rdata;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= S_VALID;
                    end else if (r_wait_cnt == TO_LAST) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_RETRY;
                        if (r_retry_cnt != 8'hFF)
                            r_retry_cnt <= r_retry_cnt + 8'd1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WW'(1);
                    end
                end
                S_RETRY: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_FETCH;
                end
                S_VALID: begin
                    if (!i_stall) begin
                        r_pc    <= i_pc_src ? w_target : r_pc + ADDR_WIDTH'(4);
                        r_valid <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed handshake/timeout/reset steps,
// then randomized fetch/stall/branch traffic checked against an expected-PC model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic [31:0] o_pc_plus8;
    logic        o_instr_valid;
    logic [7:0]  o_retry_cnt;

    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic        o_imem_req2;
    logic [31:0] o_imem_addr2;
    logic [31:0] o_instr2;
    logic [31:0] o_instr_pc2;
    logic [31:0] o_pc_plus8_2;
    logic        o_instr_valid2;
    logic [7:0]  o_retry_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_pc_src(pc_src), .i_branch_target(branch_target),
        .i_stall(stall), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata), .o_instr(o_instr),
        .o_instr_pc(o_instr_pc), .o_pc_plus8(o_pc_plus8), .o_instr_valid(o_instr_valid),
        .o_retry_cnt(o_retry_cnt)
    );

    instruction_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) dut2 (
        .i_clk(clk), .i_reset(reset), .i_pc_src(1'b0), .i_branch_target(32'h0),
        .i_stall(1'b0), .o_imem_req(o_imem_req2), .o_imem_addr(o_imem_addr2),
        .i_imem_ack(imem_ack2), .i_imem_rdata(imem_rdata2), .o_instr(o_instr2),
        .o_instr_pc(o_instr_pc2), .o_pc_plus8(o_pc_plus8_2), .o_instr_valid(o_instr_valid2),
        .o_retry_cnt(o_retry_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch at addr after dly idle FETCH cycles, then check the result.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int dly);
        chk("fetch_req", 64'(o_imem_req), 64'd1);
        chk("fetch_addr", 64'(o_imem_addr), 64'(addr));
        repeat (dly) begin
            tick();
            chk("fetch_hold_addr", 64'(o_imem_addr), 64'(addr));
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("got_valid", 64'(o_instr_valid), 64'd1);
        chk("got_instr", 64'(o_instr), 64'(data));
        chk("got_instr_pc", 64'(o_instr_pc), 64'(addr));
        chk("got_pc_plus8", 64'(o_pc_plus8), 64'(addr + 32'd8));
        chk("valid_req_low", 64'(o_imem_req), 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] exp_pc;
        logic [31:0] data;
        int          n;

        reset = 1'b1; pc_src = 1'b0; branch_target = '0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; imem_ack2 = 1'b0; imem_rdata2 = '0;
        tick();
        tick();
        chk("rst_req", 64'(o_imem_req), 64'd0);
        chk("rst_valid", 64'(o_instr_valid), 64'd0);
        chk("rst_instr", 64'(o_instr), 64'd0);
        chk("rst_retry", 64'(o_retry_cnt), 64'd0);

        reset = 1'b0;
        #1;
        do_fetch(32'h0, 32'hE3A0_1000, 0);

        tick();
        do_fetch(32'h4, 32'h1111_2222, 1);
        tick();
        do_fetch(32'h8, 32'h3333_4444, 2);

        // Stall holds the word; branch pulses while stalled are ignored.
        held  = o_instr;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc_src = (i == 2);
            branch_target = 32'h200;
            tick();
            chk("stall_valid", 64'(o_instr_valid), 64'd1);
            chk("stall_instr", 64'(o_instr), 64'(held));
            chk("stall_req", 64'(o_imem_req), 64'd0);
        end
        stall = 1'b0; pc_src = 1'b1; branch_target = 32'h107;
        tick();
        pc_src = 1'b0;
        chk("branch_addr", 64'(o_imem_addr), 64'h104);

        // Ack coincides with the timeout expiry cycle.
        repeat (15) begin
            chk("expiry_req", 64'(o_imem_req), 64'd1);
            tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'hA5A5_0001;
        tick();
        imem_ack = 1'b0;
        chk("expiry_valid", 64'(o_instr_valid), 64'd1);
        chk("expiry_retry", 64'(o_retry_cnt), 64'd0);
        tick();

        // Full timeout with no ack.
        for (int i = 0; i < 16; i++) begin
            chk("to_req", 64'(o_imem_req), 64'd1);
            tick();
        end
        chk("retry_req_low", 64'(o_imem_req), 64'd0);
        chk("retry_cnt", 64'(o_retry_cnt), 64'd1);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("retry_stray_ack", 64'(o_instr_valid), 64'd0);
        do_fetch(32'h108, 32'h5555_6666, 0);
        tick();

        // Reset mid-fetch with an ack arriving in the reset cycle.
        tick();
        tick();
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("rst_cycle_req", 64'(o_imem_req), 64'd0);
        tick();
        reset = 1'b0; imem_ack = 1'b0;
        #1;
        chk("midrst_valid", 64'(o_instr_valid), 64'd0);
        chk("midrst_req", 64'(o_imem_req), 64'd1);
        chk("midrst_addr", 64'(o_imem_addr), 64'h0);
        chk("midrst_retry", 64'(o_retry_cnt), 64'd0);

        // Random traffic against the expected-PC model.
        exp_pc = 32'h0;
        for (int it = 0; it < 40; it++) begin
            data = $urandom;
            do_fetch(exp_pc, data, $urandom_range(0, 6));
            n = $urandom_range(0, 3);
            repeat (n) begin
                stall = 1'b1; pc_src = 1'($urandom); branch_target = $urandom;
                tick();
                chk("rnd_stall_instr", 64'(o_instr), 64'(data));
                chk("rnd_stall_pc", 64'(o_instr_pc), 64'(exp_pc));
            end
            stall = 1'b0;
            pc_src = ($urandom_range(0, 3) == 0);
            branch_target = $urandom;
            exp_pc = pc_src ? (branch_target & 32'hFFFF_FFFC) : exp_pc + 32'd4;
            tick();
            pc_src = 1'b0;
            chk("rnd_accept_valid", 64'(o_instr_valid), 64'd0);
            chk("rnd_next_addr", 64'(o_imem_addr), 64'(exp_pc));
        end

        // PC wrap on the second instance.
        n = 0;
        while (!o_imem_req2 && n < 20) begin
            tick();
            n++;
        end
        chk("wrap_req", 64'(o_imem_req2), 64'd1);
        chk("wrap_addr", 64'(o_imem_addr2), 64'hFFFF_FFFC);
        imem_ack2 = 1'b1; imem_rdata2 = 32'h7777_8888;
        tick();
        imem_ack2 = 1'b0;
        chk("wrap_instr_pc", 64'(o_instr_pc2), 64'hFFFF_FFFC);
        chk("wrap_plus8", 64'(o_pc_plus8_2), 64'h4);
        tick();
        chk("wrap_next_req", 64'(o_imem_req2), 64'd1);
        chk("wrap_next_addr", 64'(o_imem_addr2), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
